// File: rtl/hamming_nibble_decoder.sv
// ============================================================================
// Module      : hamming_nibble_decoder
// Description : Hamming(7,4)-per-nibble checker/corrector with a 2-stage
//               valid/ready pipeline and a scrub write-back port.
//               Optional correction statistics: HAMMING_DEC_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hamming_nibble_decoder #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    localparam int NIB   = DATA_W / 4,
    localparam int PAR_W = 3 * NIB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NIB-1:0]    out_corr,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [PAR_W-1:0]  wb_parity,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  corr_count
);

    // {p2,p1,p0} for one nibble
    function automatic logic [2:0] f_enc(input logic [3:0] d);
        f_enc = {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // Syndromes with a single bit set point at a parity bit: data is left alone
    function automatic logic [3:0] f_flip(input logic [2:0] s);
        case (s)
            3'b011:  f_flip = 4'b0001;
            3'b101:  f_flip = 4'b0010;
            3'b110:  f_flip = 4'b0100;
            3'b111:  f_flip = 4'b1000;
            default: f_flip = 4'b0000;
        endcase
    endfunction

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [PAR_W-1:0]  r_s1_syn;
    logic [PAR_W-1:0]  r_out_parity;

    logic [PAR_W-1:0]  w_in_syn;
    logic [DATA_W-1:0] w_fix;
    logic [DATA_W-1:0] w_cor_data;
    logic [PAR_W-1:0]  w_cor_par;
    logic [NIB-1:0]    w_cor_flag;
    logic              w_s2_load;
    logic              w_in_fire;
    logic              w_out_fire;

    for (genvar i = 0; i < NIB; i++) begin : g_nib
        assign w_in_syn[3*i +: 3]  = f_enc(in_data[4*i +: 4]) ^ in_parity[3*i +: 3];
        assign w_fix[4*i +: 4]     = f_flip(r_s1_syn[3*i +: 3]);
        assign w_cor_flag[i]       = |r_s1_syn[3*i +: 3];
        assign w_cor_par[3*i +: 3] = f_enc(w_cor_data[4*i +: 4]);
    end

    assign w_cor_data = r_s1_data ^ w_fix;
    assign w_s2_load  = r_s1_valid && (!out_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_syn     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_corr     <= '0;
            r_out_parity <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_parity    <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_syn   <= w_in_syn;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                out_valid    <= 1'b1;
                out_data     <= w_cor_data;
                out_corr     <= w_cor_flag;
                r_out_parity <= w_cor_par;
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end

            // Scrub only beats that actually needed repair; data/parity hold otherwise
            wb_valid <= w_out_fire && (|out_corr);
            if (w_out_fire && (|out_corr)) begin
                wb_data   <= out_data;
                wb_parity <= r_out_parity;
            end
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    logic [CNT_W-1:0] r_corr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_corr_count <= '0;
        end else if (stats_clr) begin
            r_corr_count <= '0;
        end else if (w_out_fire && (|out_corr) && (r_corr_count != {CNT_W{1'b1}})) begin
            r_corr_count <= r_corr_count + 1'b1;
        end
    end

    assign corr_count = r_corr_count;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr;
    assign corr_count         = '0;
`endif

endmodule

`default_nettype wire
